// File: rtl/ma_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ma_stage_if                                                  |
// | Brief  : Data-memory request/response bus between MA and the memory.  |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
interface ma_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_adr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/ma_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ma_stage                                                     |
// | Brief  : Memory-access pipeline stage with held-request dmem handshake |
// |          and WB register; MA_MISALIGN_DET_EN enables misalign trapping.|
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module ma_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  ma_stage_if.master  dmem,
  output logic        stall_ma,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [31:0] wbk_data_wb2,
  output logic        misalign_ma
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [29:0] r_adr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_ld;
  logic        r_wen;
  logic        r_kill;
  logic [2:0]  r_code;
  logic [1:0]  r_off;
  logic [4:0]  r_rd_adr;
  logic [31:0] r_rdata;
  logic [4:0]  r_rd_adr_wb;
  logic        r_wbk_en;
  logic [31:0] r_wbk_data;
  logic [31:0] r_wbk_data2;

  logic        w_mem;
  logic        w_misalign;
  logic        w_issue;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem    = cmd_ld_ma | cmd_st_ma;
  assign w_off    = rd_data_ma[1:0];
  assign w_issue  = (r_state == ST_IDLE) && w_mem && !w_misalign && !rst_pipe;
  assign stall_ma = w_issue || (r_state == ST_BUSY);

`ifdef MA_MISALIGN_DET_EN
  logic r_misalign;

  assign w_misalign = ((ldst_code_ma[1:0] == 2'b01) && w_off[0]) ||
                      ((ldst_code_ma[1:0] == 2'b10) && (w_off != 2'b00));

  // Pulse only when the offending instruction actually leaves MA.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == ST_IDLE) && w_mem && w_misalign && !rst_pipe && !stall;
    end
  end

  assign misalign_ma = r_misalign;
`else
  assign w_misalign  = 1'b0;
  assign misalign_ma = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = st_data_ma;
    case (ldst_code_ma[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{st_data_ma[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata = {2{st_data_ma[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = r_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_code)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 30'd0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_ld        <= 1'b0;
      r_wen       <= 1'b0;
      r_kill      <= 1'b0;
      r_code      <= 3'd0;
      r_off       <= 2'd0;
      r_rd_adr    <= 5'd0;
      r_rdata     <= 32'd0;
      r_rd_adr_wb <= 5'd0;
      r_wbk_en    <= 1'b0;
      r_wbk_data  <= 32'd0;
      r_wbk_data2 <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state  <= ST_BUSY;
            r_req    <= 1'b1;
            r_we     <= cmd_st_ma;
            r_adr    <= rd_data_ma[31:2];
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_ld     <= cmd_ld_ma;
            r_wen    <= wbk_rd_reg_ma;
            r_kill   <= 1'b0;
            r_code   <= ldst_code_ma;
            r_off    <= w_off;
            r_rd_adr <= rd_adr_ma;
          end else if (rst_pipe) begin
            r_wbk_en <= 1'b0;
          end else if (!stall) begin
            // A trapped misaligned access retires here without writing back.
            r_rd_adr_wb <= rd_adr_ma;
            r_wbk_en    <= wbk_rd_reg_ma && !w_mem;
            if (!w_mem) begin
              r_wbk_data  <= rd_data_ma;
              r_wbk_data2 <= r_wbk_data;
            end
          end
        end
        ST_BUSY: begin
          if (rst_pipe) begin
            r_kill <= 1'b1;
          end
          if (dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_rdata <= dmem.dmem_rdata;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_rd_adr_wb <= r_rd_adr;
          r_wbk_en    <= r_ld && r_wen && !r_kill && !rst_pipe;
          // Stores leave the WB data pair untouched.
          if (r_ld) begin
            r_wbk_data  <= w_load;
            r_wbk_data2 <= r_wbk_data;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_adr   = r_adr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign rd_adr_wb     = r_rd_adr_wb;
  assign wbk_rd_reg_wb = r_wbk_en;
  assign wbk_data_wb   = r_wbk_data;
  assign wbk_data_wb2  = r_wbk_data2;

endmodule
`default_nettype wire

// File: tb/tb_ma_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ma_stage                                                  |
// | Brief  : Directed + random bench for ma_stage with byte-memory model. |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_ma_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, rst_pipe, ext_stall;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        stall, stall_ma, wbk_rd_reg_wb, misalign_ma;
  logic [4:0]  rd_adr_wb;
  logic [31:0] wbk_data_wb, wbk_data_wb2;

  always #5 clk = ~clk;
  assign stall = stall_ma | ext_stall;

  ma_stage_if dmem_if ();

  ma_stage dut (
    .clk(clk), .rst_n(rst_n), .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
    .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma),
    .st_data_ma(st_data_ma), .ldst_code_ma(ldst_code_ma), .stall(stall),
    .rst_pipe(rst_pipe), .dmem(dmem_if), .stall_ma(stall_ma), .rd_adr_wb(rd_adr_wb),
    .wbk_rd_reg_wb(wbk_rd_reg_wb), .wbk_data_wb(wbk_data_wb),
    .wbk_data_wb2(wbk_data_wb2), .misalign_ma(misalign_ma)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [int unsigned];
  logic [4:0]  m_rd;
  logic        m_en;
  logic [31:0] m_data, m_data2;
  logic [2:0]  codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int unsigned a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int size_of(input logic [2:0] code);
    case (code[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic set_word(input int unsigned a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
  endtask

  task automatic model_wb(input logic [4:0] rd, input logic en, input bit upd, input logic [31:0] d);
    m_rd = rd;
    m_en = en;
    if (upd) begin
      m_data2 = m_data;
      m_data  = d;
    end
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_rd_adr_wb"}, 32'(rd_adr_wb), 32'(m_rd));
    check({tag, "_wbk_en"}, 32'(wbk_rd_reg_wb), 32'(m_en));
    check({tag, "_wbk_data"}, wbk_data_wb, m_data);
    check({tag, "_wbk_data2"}, wbk_data_wb2, m_data2);
  endtask

  task automatic bubble_inputs();
    cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; rd_adr_ma = 5'd0; rd_data_ma = 32'd0;
    wbk_rd_reg_ma = 1'b0; st_data_ma = 32'd0; ldst_code_ma = 3'd0;
    rst_pipe = 1'b0; ext_stall = 1'b0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bubble_inputs();
    repeat (2) @(negedge clk);
    m_rd = 5'd0; m_en = 1'b0; m_data = 32'd0; m_data2 = 32'd0;
    check("rst_req", 32'(dmem_if.dmem_req), 32'd0);
    check("rst_we", 32'(dmem_if.dmem_we), 32'd0);
    check("rst_adr", 32'(dmem_if.dmem_adr), 32'd0);
    check("rst_be", 32'(dmem_if.dmem_be), 32'd0);
    check("rst_wdata", dmem_if.dmem_wdata, 32'd0);
    check("rst_stall", 32'(stall_ma), 32'd0);
    check("rst_misalign", 32'(misalign_ma), 32'd0);
    check_wb("rst");
    rst_n = 1'b1;
  endtask

  task automatic alu_op(input logic [31:0] data, input logic [4:0] rd, input bit wen,
                        input bit ext, input bit flush, input bit stray);
    cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; rd_data_ma = data; rd_adr_ma = rd;
    wbk_rd_reg_ma = wen; ldst_code_ma = 3'($urandom); st_data_ma = $urandom;
    ext_stall = ext; rst_pipe = flush;
    dmem_if.dmem_ack = stray; dmem_if.dmem_rdata = $urandom;
    #1 check("alu_stall", 32'(stall_ma), 32'd0);
    @(negedge clk);
    ext_stall = 1'b0; rst_pipe = 1'b0; dmem_if.dmem_ack = 1'b0;
    if (flush) m_en = 1'b0;
    else if (!ext) model_wb(rd, wen, 1'b1, data);
    check("alu_req", 32'(dmem_if.dmem_req), 32'd0);
    check("alu_misalign", 32'(misalign_ma), 32'd0);
    check_wb("alu");
  endtask

  task automatic mem_op(input bit is_st, input logic [2:0] code, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input bit wen,
                        input int n_busy, input bit flush);
    int          sz, stalls, reqs;
    logic [31:0] eff, word, exp_ld, exp_wd;
    logic [3:0]  exp_be;
    sz     = size_of(code);
    eff    = addr & ~(32'(sz) - 32'd1);
    exp_be = 4'(((32'd1 << sz) - 32'd1) << eff[1:0]);
    for (int i = 0; i < 4; i++) word[8*i +: 8] = get_byte({eff[31:2], 2'b00} + i);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sdata[8*(i % sz) +: 8];
    exp_ld = 32'd0;
    for (int i = 0; i < sz; i++) exp_ld[8*i +: 8] = get_byte(eff + i);
    if (!code[2] && sz < 4 && exp_ld[8*sz-1]) exp_ld |= ~((32'd1 << (8*sz)) - 32'd1);

    cmd_ld_ma = !is_st; cmd_st_ma = is_st; ldst_code_ma = code; rd_data_ma = addr;
    st_data_ma = sdata; rd_adr_ma = rd; wbk_rd_reg_ma = wen; ext_stall = 1'b0; rst_pipe = 1'b0;
    #1 stalls = int'(stall_ma);
    reqs = 0;
    @(negedge clk);
    for (int c = 1; c <= n_busy; c++) begin
      reqs   += int'(dmem_if.dmem_req);
      stalls += int'(stall_ma);
      if (c == 1) begin
        check("req_we", 32'(dmem_if.dmem_we), 32'(is_st));
        check("req_adr", 32'(dmem_if.dmem_adr), 32'(eff[31:2]));
        check("req_be", 32'(dmem_if.dmem_be), 32'(exp_be));
        if (is_st) check("req_wdata", dmem_if.dmem_wdata, exp_wd);
      end
      rst_pipe = flush && (c == 1);
      if (c == n_busy) begin
        dmem_if.dmem_ack = 1'b1;
        dmem_if.dmem_rdata = word;
      end
      @(negedge clk);
      dmem_if.dmem_ack = 1'b0;
      dmem_if.dmem_rdata = $urandom;
      rst_pipe = 1'b0;
    end
    stalls += int'(stall_ma);
    check("done_req", 32'(dmem_if.dmem_req), 32'd0);
    check("req_cycles", 32'(reqs), 32'(n_busy));
    check("stall_cycles", 32'(stalls), 32'(n_busy + 1));
    @(negedge clk);
    if (is_st) begin
      for (int i = 0; i < sz; i++) mem[eff + i] = sdata[8*i +: 8];
      model_wb(rd, 1'b0, 1'b0, 32'd0);
    end else begin
      model_wb(rd, wen && !flush, 1'b1, exp_ld);
    end
    check_wb(is_st ? "st" : "ld");
  endtask

`ifdef MA_MISALIGN_DET_EN
  task automatic misalign_op(input logic [2:0] code, input logic [31:0] addr, input logic [4:0] rd);
    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = code; rd_data_ma = addr;
    rd_adr_ma = rd; wbk_rd_reg_ma = 1'b1; ext_stall = 1'b0; rst_pipe = 1'b0;
    #1 check("mis_stall", 32'(stall_ma), 32'd0);
    @(negedge clk);
    cmd_ld_ma = 1'b0;
    check("mis_req", 32'(dmem_if.dmem_req), 32'd0);
    check("mis_flag", 32'(misalign_ma), 32'd1);
    model_wb(rd, 1'b0, 1'b0, 32'd0);
    check_wb("mis");
  endtask
`endif

  initial begin
    do_reset();

    set_word(32'h100, 32'hDEADBEEF);
    mem_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd3, 1'b1, 1, 1'b0);
    check("lw_result", wbk_data_wb, 32'hDEADBEEF);

    set_word(32'h100, 32'h80FFFF00);
    mem_op(1'b0, 3'b000, 32'h103, 32'd0, 5'd4, 1'b1, 1, 1'b0);
    check("lb_result", wbk_data_wb, 32'hFFFFFF80);
    mem_op(1'b0, 3'b100, 32'h103, 32'd0, 5'd5, 1'b1, 2, 1'b0);
    check("lbu_result", wbk_data_wb, 32'h00000080);

    mem_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd6, 1'b1, 1, 1'b0);
    check("sh_en", 32'(wbk_rd_reg_wb), 32'd0);

    alu_op(32'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    alu_op(32'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fwd_wb2", wbk_data_wb2, 32'd5);

    mem_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd9, 1'b1, 4, 1'b1);
    check("flush_en", 32'(wbk_rd_reg_wb), 32'd0);

    alu_op(32'h1111, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    alu_op(32'h2222, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    alu_op(32'h3333, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef MA_MISALIGN_DET_EN
    misalign_op(3'b010, 32'h101, 5'd13);
    alu_op(32'h4444, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    mem_op(1'b0, 3'b010, 32'h101, 32'd0, 5'd13, 1'b1, 1, 1'b0);
`endif

    // Reset while a request is outstanding.
    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = 3'b010; rd_data_ma = 32'h140;
    rd_adr_ma = 5'd15; wbk_rd_reg_ma = 1'b1;
    @(negedge clk);
    check("rb_req_on", 32'(dmem_if.dmem_req), 32'd1);
    rst_n = 1'b0;
    cmd_ld_ma = 1'b0;
    @(negedge clk);
    m_rd = 5'd0; m_en = 1'b0; m_data = 32'd0; m_data2 = 32'd0;
    check("rb_req_off", 32'(dmem_if.dmem_req), 32'd0);
    check("rb_stall", 32'(stall_ma), 32'd0);
    check_wb("rb");
    rst_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [2:0]  code;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        alu_op($urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0);
      end else begin
        code = (kind == 2) ? codes[$urandom_range(0, 2)] : codes[$urandom_range(0, 4)];
        addr = 32'h300 + $urandom_range(0, 31);
`ifdef MA_MISALIGN_DET_EN
        addr = addr & ~(32'(size_of(code)) - 32'd1);
`endif
        mem_op(kind == 2, code, addr, $urandom, 5'($urandom), 1'($urandom),
               $urandom_range(1, 3), $urandom_range(0, 5) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
